mpmc11_fifo_rd_arb: RTL
=======================

Name: mpmc11_fifo_rd_arb

Overview:
- Read-side scheduler for the bank of per-port asynchronous request FIFOs in mpmc11.
- Each FIFO runs in FWFT mode. The block picks one non-empty FIFO per grant by round-robin, captures its head entry and pops it in the same cycle.
- It presents the captured entry to the memory-controller state machine with a valid/ready handshake and handles retry (rty) by re-presenting the held entry after a back-off.

Parameters:
- NPORT, 8, number of FIFOs arbitrated (2..16).
- RETRY_DLY, 4, cycles req_valid stays low after a retry before re-presenting (1..255).
- MAX_RETRY, 15, retries allowed per entry before it is dropped (1..255).

Ports:
- rd_clk  input  1  read-domain clock.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  NPORT  empty flag per FIFO.
- fifo_rst_busy  input  NPORT  rd_rst_busy per FIFO.
- fifo_prog_full  input  NPORT  prog_full per FIFO; only used with the optional feature.
- fifo_dout  input  NPORT x $bits(mpmc11_fifoe_t)  FWFT head entry per FIFO.
- fifo_rd  output  NPORT  one-hot pop strobe.
- req_o  output  $bits(mpmc11_fifoe_t)  captured entry.
- req_port  output  $clog2(NPORT)  source FIFO index of req_o.
- req_valid  output  1  req_o is valid.
- req_ready  input  1  consumer accepts req_o.
- rty  input  1  consumer rejects req_o; retry it.
- rty_cnt  output  8  retries of the current entry, saturating.
- err_drop  output  1  one-cycle pulse when an entry is discarded at MAX_RETRY.
- busy  output  1  state != IDLE.

Behaviour:
- Reset is synchronous active-high on rd_clk. While rst is high, fifo_rd is forced to 0 combinationally.
- Reset values: req_valid=0, req_o=0, req_port=0, rty_cnt=0, err_drop=0, busy=0, state=IDLE.
- Round-robin pointer last resets to NPORT-1, so port 0 wins first.
- A port is eligible when fifo_empty[i]=0 and fifo_rst_busy[i]=0.
- Grant: search starts at last+1 and wraps modulo NPORT. The first eligible port wins and last updates to it.
- Capture/pop: in the grant cycle, fifo_rd[g]=1 (one-hot, exactly one cycle) and fifo_dout[g] is registered into req_o. req_port=g, rty_cnt=0.
- Latency: eligible port seen in IDLE -> fifo_rd that cycle -> req_valid=1 the next cycle.
- States: IDLE, VALID, RETRY.
  - IDLE: if any port is eligible, grant and go to VALID; else stay in IDLE.
  - VALID: req_valid=1. req_o and req_port are held stable while req_ready=0.
    - req_ready=1, rty=0: entry accepted. If another port is eligible that cycle, grant it and stay in VALID (back-to-back throughput of one entry per cycle). Else go to IDLE with req_valid=0.
    - rty=1 (dominates req_ready), rty_cnt+1 < MAX_RETRY: rty_cnt increments, go to RETRY with a delay counter loaded with RETRY_DLY. There is no pop.
    - rty=1, rty_cnt+1 >= MAX_RETRY: err_drop pulses, the entry is discarded, go to IDLE.
  - RETRY: req_valid=0 and the delay counter decrements each cycle. When it reaches 0, go to VALID and re-present the identical req_o/req_port. No FIFO is popped in RETRY.
- rty_cnt saturates at 255 and is cleared on each new capture.
- fifo_rst_busy rising on a port mid-operation does not affect an entry already captured; that port is only masked from further grants.
- rst asserted mid-operation: the held entry is lost (it was already popped) and all outputs return to their reset values next cycle.
- A pop never occurs unless the selected port is eligible. With no eligible ports, fifo_rd stays 0.

Optional Feature:
- Macro: MPMC11_FIFO_ARB_URGENT_EN.
- Defined: eligible ports with fifo_prog_full=1 form an urgent set. If that set is non-empty, the round-robin search (same pointer) runs over the urgent set only; otherwise it runs over all eligible ports.
- Undefined: fifo_prog_full is ignored and there is plain round-robin over all eligible ports.

Test Plan:
1. Reset, then port 2 non-empty with entry 0xA5.. -> fifo_rd=8'h04 for one cycle; next cycle req_valid=1, req_port=2, req_o=0xA5..; all outputs 0 during rst.
2. Ports 0,3,5 continuously non-empty, req_ready=1, rty=0 -> grant order 0,3,5,0,3,5 with one fifo_rd per cycle and req_valid continuously high.
3. req_ready=0 for 10 cycles with an entry held -> req_o/req_port stable and fifo_rd=0 throughout; req_ready=1 -> accepted, next port granted.
4. rty=1 on first presentation, RETRY_DLY=4 -> req_valid=0 for 4 cycles, same req_o re-presented, rty_cnt=1, no extra fifo_rd.
5. MAX_RETRY=3, rty held high -> third rty produces an err_drop pulse and return to IDLE; the next eligible port is granted afterwards.
6. Port 1 non-empty, port 6 non-empty with prog_full=1, last=0 -> port 6 granted first with MPMC11_FIFO_ARB_URGENT_EN defined, port 1 first without it; port 4 with fifo_rst_busy=1 is never popped.

Source files
------------

// File: rtl/mpmc11_fifo_rd_arb.sv
// mpmc11_fifo_rd_arb: read-side scheduler for the mpmc11 per-port request FIFOs.
// Picks one eligible FWFT FIFO per grant by round-robin, pops it while capturing
// its head entry, and presents that entry to the memory-controller FSM with a
// valid/ready handshake. A retry (rty) re-presents the held entry after a back-off;
// entries that exhaust MAX_RETRY are dropped with an err_drop pulse.
//
// Optional feature macro: MPMC11_FIFO_ARB_URGENT_EN
//   When defined, eligible ports with fifo_prog_full=1 are served ahead of the
//   others, still using the shared round-robin pointer.
//
// ENTRY_W must equal $bits(mpmc11_fifoe_t) of the surrounding design.

module mpmc11_fifo_rd_arb #(
    parameter int unsigned NPORT     = 8,
    parameter int unsigned RETRY_DLY = 4,
    parameter int unsigned MAX_RETRY = 15,
    parameter int unsigned ENTRY_W   = 64,
    localparam int unsigned PW       = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic                            rd_clk,
    input  logic                            rst,
    input  logic [NPORT-1:0]                fifo_empty,
    input  logic [NPORT-1:0]                fifo_rst_busy,
    input  logic [NPORT-1:0]                fifo_prog_full,
    input  logic [NPORT-1:0][ENTRY_W-1:0]   fifo_dout,
    output logic [NPORT-1:0]                fifo_rd,
    output logic [ENTRY_W-1:0]              req_o,
    output logic [PW-1:0]                   req_port,
    output logic                            req_valid,
    input  logic                            req_ready,
    input  logic                            rty,
    output logic [7:0]                      rty_cnt,
    output logic                            err_drop,
    output logic                            busy
);

    typedef enum logic [1:0] {
        StIdle,
        StValid,
        StRetry
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       last_q, last_d;
    logic [ENTRY_W-1:0]  req_q, req_d;
    logic [PW-1:0]       port_q, port_d;
    logic [7:0]          rty_cnt_q, rty_cnt_d;
    logic [7:0]          dly_q, dly_d;
    logic                err_drop_q, err_drop_d;

    logic [NPORT-1:0]    eligible;
    logic [NPORT-1:0]    cand;
    logic                gnt_found;
    logic [PW-1:0]       gnt_idx;
    logic [31:0]         pos;
    logic                do_grant;
    logic [8:0]          rty_inc;

    // A FIFO can be popped only when it holds data and is out of its read reset.
    assign eligible = ~fifo_empty & ~fifo_rst_busy;

`ifdef MPMC11_FIFO_ARB_URGENT_EN
    logic [NPORT-1:0] urgent;

    // Near-full FIFOs pre-empt the rest; fall back to all eligible ports otherwise.
    assign urgent = eligible & fifo_prog_full;
    assign cand   = (|urgent) ? urgent : eligible;
`else
    logic unused_prog_full;

    assign unused_prog_full = ^fifo_prog_full;
    assign cand             = eligible;
`endif

    // Round-robin search starting one past the last granted port, wrapping modulo NPORT.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        pos       = '0;
        for (int unsigned k = 1; k <= NPORT; k++) begin
            pos = (32'(last_q) + k) % NPORT;
            if (!gnt_found && cand[pos[PW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = pos[PW-1:0];
            end
        end
    end

    assign rty_inc = {1'b0, rty_cnt_q} + 9'd1;

    // Next-state logic: handshake, retry back-off and grant/capture.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        req_d      = req_q;
        port_d     = port_q;
        rty_cnt_d  = rty_cnt_q;
        dly_d      = dly_q;
        err_drop_d = 1'b0;
        do_grant   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    do_grant = 1'b1;
                    state_d  = StValid;
                end
            end
            StValid: begin
                // rty outranks req_ready; the held entry is never popped again.
                if (rty) begin
                    rty_cnt_d = (rty_cnt_q == 8'hFF) ? 8'hFF : rty_inc[7:0];
                    if (rty_inc >= 9'(MAX_RETRY)) begin
                        err_drop_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        dly_d   = 8'(RETRY_DLY);
                        state_d = StRetry;
                    end
                end else if (req_ready) begin
                    if (gnt_found) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StRetry: begin
                // Leaves after exactly RETRY_DLY cycles with req_valid low.
                dly_d = dly_q - 8'd1;
                if (dly_q <= 8'd1) begin
                    state_d = StValid;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (do_grant) begin
            last_d    = gnt_idx;
            req_d     = fifo_dout[gnt_idx];
            port_d    = gnt_idx;
            rty_cnt_d = '0;
        end
    end

    // One-hot pop strobe in the grant cycle, suppressed while reset is asserted.
    always_comb begin
        fifo_rd = '0;
        if (do_grant && !rst) begin
            fifo_rd[gnt_idx] = 1'b1;
        end
    end

    // State and captured-entry registers with synchronous reset.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_q    <= StIdle;
            last_q     <= PW'(NPORT - 1);
            req_q      <= '0;
            port_q     <= '0;
            rty_cnt_q  <= '0;
            dly_q      <= '0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            req_q      <= req_d;
            port_q     <= port_d;
            rty_cnt_q  <= rty_cnt_d;
            dly_q      <= dly_d;
            err_drop_q <= err_drop_d;
        end
    end

    assign req_o     = req_q;
    assign req_port  = port_q;
    assign req_valid = (state_q == StValid);
    assign rty_cnt   = rty_cnt_q;
    assign err_drop  = err_drop_q;
    assign busy      = (state_q != StIdle);

endmodule
